// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch sequencer.
// Owns the program counter and keeps at most one instruction-memory request
// in flight. Responses land in a one-entry instruction register handed to
// decode over a valid/ready handshake. A redirect from execute retargets the
// pc and discards any stale fetch still in flight.
//
// Optional feature macro: FETCH_FLUSH_NOP_EN
//   defined   : a redirect loads the instruction register with a NOP bubble
//               (addi x0,x0,0). ir_pc keeps its previous value.
//   undefined : a redirect only clears ir_valid. ir and ir_pc hold.
module fetch_unit #(
  parameter logic [31:0] INIT_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] issued_addr;
  logic [31:0] issued_next;
  logic [31:0] redirect_target;
  logic        req_fire;
  logic        load;
  logic        consume;

  // Word-aligned redirect target; the low two bits are forced to zero.
  assign redirect_target = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};

  // A new request goes out only when the buffer is free or being emptied this
  // cycle, so a response can always be captured. It never looks at ready.
  assign imem_req_valid = (state == REQ) && (!ir_valid || ir_ready);
  assign imem_req_addr  = {pc[31:2], pc[1:0] & 2'b00};

  assign req_fire = imem_req_valid && imem_req_ready;
  assign consume  = ir_valid && ir_ready;

  // State, program counter and issued-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= {INIT_PC[31:2], 2'b00};
      issued_addr <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      issued_addr <= issued_next;
    end
  end

  // Next-state, next-pc and buffer-load decision; redirect overrides all.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    issued_next = issued_addr;
    load        = 1'b0;

    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (req_fire) begin
          state_next  = WAIT;
          issued_next = pc;
          pc_next     = pc + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      pc_next = redirect_target;
      load    = 1'b0;
      unique case (state)
        IDLE:    state_next = REQ;
        // A request accepted in the redirect cycle is already stale.
        REQ:     state_next = req_fire ? DRAIN : REQ;
        WAIT:    state_next = imem_rsp_valid ? REQ : DRAIN;
        // The stale response returning now ends the drain; otherwise keep
        // draining with the newer target already in pc.
        DRAIN:   state_next = imem_rsp_valid ? REQ : DRAIN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Instruction register: flush on redirect, load on response, clear on consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
    end else if (redirect_valid) begin
`ifdef FETCH_FLUSH_NOP_EN
      ir_valid <= 1'b1;
      ir       <= NOP_INSN;
`else
      ir_valid <= 1'b0;
`endif
    end else if (load) begin
      ir_valid <= 1'b1;
      ir       <= imem_rsp_data;
      ir_pc    <= issued_addr;
    end else if (consume) begin
      ir_valid <= 1'b0;
    end
  end

`ifndef FETCH_FLUSH_NOP_EN
  // The bubble constant is only consumed by the NOP-flush build.
  logic nop_unused;
  assign nop_unused = ^NOP_INSN;
`endif

endmodule
